// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: funct codes used by ALU control and the
// HI/LO multiplier, plus the multiplier state encoding.
package mips_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } mult_state_e;

    function automatic logic is_mul_funct(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_MULTU);
    endfunction

    // Any funct that touches HI/LO must wait while a multiply is in flight.
    function automatic logic is_hilo_funct(input logic [5:0] funct);
        return is_mul_funct(funct) || (funct == F_MFHI) || (funct == F_MFLO);
    endfunction

endpackage

// File: rtl/mult_hilo_unit_if.sv
// EX-stage bundle between the pipeline and the HI/LO multiplier.
interface mult_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             ex_valid;
    logic [5:0]       multCtl;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output ex_valid, multCtl, dataA, dataB,
        input  hi, lo, mf_data, busy, done, stall
    );

    modport slave (
        input  ex_valid, multCtl, dataA, dataB,
        output hi, lo, mf_data, busy, done, stall
    );
endinterface

// File: rtl/shift_add_step.sv
// One shift-add multiply iteration: add the multiplicand into the upper half
// when the product LSB is set, then shift {carry, product} right by one.
module shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   mcand,
    input  logic [2*WIDTH-1:0] prod_in,
    output logic [2*WIDTH-1:0] prod_out
);

    logic [WIDTH:0] sum_s;

    // Conditional add keeps the carry, which becomes the new MSB after the shift.
    always_comb begin
        if (prod_in[0]) begin
            sum_s = {1'b0, prod_in[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum_s = {1'b0, prod_in[2*WIDTH-1:WIDTH]};
        end
        prod_out = {sum_s, prod_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_hilo_unit.sv
// Sequential 32-iteration shift-add multiplier with architectural HI/LO,
// serving mult/multu/mfhi/mflo and stalling the pipeline while busy.
module mult_hilo_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    mult_hilo_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

    mult_state_e        state_r;
    mult_state_e        state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] prod_r;
    logic               sign_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               is_signed_s;
    logic               sign_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] result_s;
    logic [WIDTH-1:0]   mf_data_s;
    logic               stall_s;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .mcand   (mcand_r),
        .prod_in (prod_r),
        .prod_out(step_s)
    );

    // Next-state logic; a multiply is only taken from IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.ex_valid && is_mul_funct(bus.multCtl)) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand magnitudes and final sign fix-up; 0x80000000 negates to itself,
    // which is exactly its unsigned magnitude.
    always_comb begin
        is_signed_s = (bus.multCtl == F_MULT);
        if (is_signed_s && bus.dataA[WIDTH-1]) begin
            mag_a_s = ~bus.dataA + ONE_W;
        end else begin
            mag_a_s = bus.dataA;
        end
        if (is_signed_s && bus.dataB[WIDTH-1]) begin
            mag_b_s = ~bus.dataB + ONE_W;
        end else begin
            mag_b_s = bus.dataB;
        end
        if (is_signed_s) begin
            sign_s = bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
        end else begin
            sign_s = 1'b0;
        end
        if (sign_r) begin
            result_s = ~prod_r + ONE_2W;
        end else begin
            result_s = prod_r;
        end
    end

    // Datapath and status registers; reset also aborts an in-flight multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            sign_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_FIN);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mcand_r <= mag_a_s;
                        prod_r  <= {{WIDTH{1'b0}}, mag_b_s};
                        sign_r  <= sign_s;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    prod_r <= step_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                end
                ST_FIN: begin
                    hi_r <= result_s[2*WIDTH-1:WIDTH];
                    lo_r <= result_s[WIDTH-1:0];
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // HI/LO read port and hazard request.
    always_comb begin
        case (bus.multCtl)
            F_MFHI:  mf_data_s = hi_r;
            F_MFLO:  mf_data_s = lo_r;
            default: mf_data_s = {WIDTH{1'b0}};
        endcase
        stall_s = bus.ex_valid && is_hilo_funct(bus.multCtl) && (state_r != ST_IDLE);
    end

    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.mf_data = mf_data_s;
    assign bus.stall   = stall_s;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Randomized self-checking bench for mult_hilo_unit against a plain-arithmetic
// 64-bit product model with cycle-accurate busy/done/stall expectations.
module tb_mult_hilo_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_unit_if #(.WIDTH(W)) mif ();

    mult_hilo_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (mif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi = 32'd0;
    logic [W-1:0] exp_lo = 32'd0;
    logic [5:0] fn_tab [6] = '{F_MULT, F_MULTU, F_MFHI, F_MFLO, 6'd0, 6'd32};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_product(input logic [5:0] f, input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (f == F_MULT) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic hilo_req(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO);
    endfunction

    function automatic logic [31:0] ref_mf(input logic [5:0] f);
        if (f == F_MFHI) return exp_hi;
        if (f == F_MFLO) return exp_lo;
        return 32'd0;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic ev, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        mif.ex_valid = ev;
        mif.multCtl  = f;
        mif.dataA    = a;
        mif.dataB    = b;
        #1;
    endtask

    // mode 0: random traffic while busy; mode 1: mflo held from cycle 5;
    // mode 2: next multiply (nf/na/nb) held from cycle 10.
    task automatic do_mult(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int mode, input logic [5:0] nf, input logic [31:0] na,
                           input logic [31:0] nb);
        logic [63:0] p;
        logic ev;
        logic [5:0] cf;
        drive(1'b1, f, a, b);
        check_eq("accept_busy", 64'(mif.busy), 64'd0);
        check_eq("accept_stall", 64'(mif.stall), 64'd0);
        tick();
        for (int c = 1; c <= 33; c++) begin
            if (mode == 1 && c >= 5) begin
                drive(1'b1, F_MFLO, $urandom(), $urandom());
            end else if (mode == 2 && c >= 10) begin
                drive(1'b1, nf, na, nb);
            end else begin
                drive(1'($urandom_range(0, 1)), fn_tab[$urandom_range(0, 5)], pick_operand(),
                      pick_operand());
            end
            ev = mif.ex_valid;
            cf = mif.multCtl;
            check_eq("run_busy", 64'(mif.busy), 64'd1);
            check_eq("run_done", 64'(mif.done), 64'(c == 33));
            check_eq("run_stall", 64'(mif.stall), 64'(ev && hilo_req(cf)));
            check_eq("run_mf_old", 64'(mif.mf_data), 64'(ref_mf(cf)));
            tick();
        end
        p = ref_product(f, a, b);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        check_eq("hi", 64'(mif.hi), 64'(exp_hi));
        check_eq("lo", 64'(mif.lo), 64'(exp_lo));
        check_eq("post_busy", 64'(mif.busy), 64'd0);
        check_eq("post_done", 64'(mif.done), 64'd0);
        if (mode == 1) begin
            check_eq("mflo_new", 64'(mif.mf_data), 64'(exp_lo));
            check_eq("mflo_stall", 64'(mif.stall), 64'd0);
        end
        if (mode != 2) begin
            drive(1'b1, F_MFHI, $urandom(), $urandom());
            check_eq("mfhi_new", 64'(mif.mf_data), 64'(exp_hi));
            check_eq("mfhi_stall", 64'(mif.stall), 64'd0);
            drive(1'b0, 6'd0, 32'd0, 32'd0);
        end
    endtask

    // Idle cycles with non-multiply functs must leave HI/LO and the FSM alone.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), fn_tab[$urandom_range(2, 5)], $urandom(), $urandom());
            check_eq("idle_stall", 64'(mif.stall), 64'd0);
            check_eq("idle_mf", 64'(mif.mf_data), 64'(ref_mf(mif.multCtl)));
            tick();
            check_eq("idle_busy", 64'(mif.busy), 64'd0);
            check_eq("idle_hilo", {32'(mif.hi), 32'(mif.lo)}, {exp_hi, exp_lo});
        end
    endtask

    initial begin
        logic [5:0] rf;
        drive(1'b1, F_MULT, 32'd5, 32'd6);
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_hi", 64'(mif.hi), 64'd0);
        check_eq("rst_lo", 64'(mif.lo), 64'd0);
        check_eq("rst_busy", 64'(mif.busy), 64'd0);
        check_eq("rst_done", 64'(mif.done), 64'd0);
        check_eq("rst_stall", 64'(mif.stall), 64'd0);
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        tick();

        do_mult(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6'd0, 32'd0, 32'd0);
        check_eq("multu_max_hi", 64'(mif.hi), 64'h0000_0000_FFFF_FFFE);
        check_eq("multu_max_lo", 64'(mif.lo), 64'h0000_0000_0000_0001);
        do_mult(F_MULT, 32'hFFFF_FFFD, 32'd7, 0, 6'd0, 32'd0, 32'd0);
        check_eq("mult_neg_hi", 64'(mif.hi), 64'h0000_0000_FFFF_FFFF);
        check_eq("mult_neg_lo", 64'(mif.lo), 64'h0000_0000_FFFF_FFEB);
        do_mult(F_MULT, 32'h8000_0000, 32'd2, 1, 6'd0, 32'd0, 32'd0);
        check_eq("mult_min_hi", 64'(mif.hi), 64'h0000_0000_FFFF_FFFF);
        check_eq("mult_min_lo", 64'(mif.lo), 64'h0000_0000_0000_0000);
        idle_cycles(3);

        do_mult(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 2, F_MULTU, 32'hDEAD_BEEF, 32'd3);
        do_mult(F_MULTU, 32'hDEAD_BEEF, 32'd3, 0, 6'd0, 32'd0, 32'd0);

        // Abort in cycle 20 of a run.
        drive(1'b1, F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        tick();
        for (int c = 1; c <= 19; c++) begin
            drive(1'b0, 6'd0, 32'd0, 32'd0);
            check_eq("abort_run_done", 64'(mif.done), 64'd0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check_eq("abort_busy", 64'(mif.busy), 64'd0);
        check_eq("abort_done", 64'(mif.done), 64'd0);
        check_eq("abort_hilo", {32'(mif.hi), 32'(mif.lo)}, 64'd0);
        do_mult(F_MULTU, 32'd123456, 32'd654321, 0, 6'd0, 32'd0, 32'd0);

        for (int i = 0; i < 20; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? F_MULT : F_MULTU;
            do_mult(rf, pick_operand(), pick_operand(), int'($urandom_range(0, 1)),
                    6'd0, 32'd0, 32'd0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Sequential 32-cycle shift-add multiplier with architectural HI/LO registers, sitting directly downstream of ALU control in the EX stage. It consumes the 6-bit function code that ALU control forwards on its multiply-control output, plus the two EX-stage operands. It executes `mult`/`multu`, serves `mfhi`/`mflo` reads, and raises a stall request while a multiply is in flight.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `F_MULT`, 6'd24: funct code for signed multiply.
- `F_MULTU`, 6'd25: funct code for unsigned multiply.
- `F_MFHI`, 6'd16: funct code for move-from-HI.
- `F_MFLO`, 6'd18: funct code for move-from-LO.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ex_valid`  in  1  EX stage holds a valid R-type instruction this cycle.
- `multCtl`  in  6  funct code from ALU control.
- `dataA`  in  WIDTH  rs operand (multiplicand).
- `dataB`  in  WIDTH  rt operand (multiplier).
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `mf_data`  out  WIDTH  combinational: `hi` for F_MFHI, `lo` for F_MFLO, else 0.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse when HI/LO take the new product.
- `stall`  out  1  hazard request to the pipeline.

## Operation
- States: IDLE, RUN, FIN. Reset sets the state to IDLE, clears the counter to 0, and clears HI, LO, the product register and the sign flag. Output reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0.
- Accept: in IDLE, if `ex_valid` and `multCtl` is F_MULT or F_MULTU, then on that edge:
  - latch multiplicand = |dataA| and product = {0, |dataB|};
  - set the sign flag to dataA[31]^dataB[31];
  - for F_MULTU, magnitudes are the raw operands and the sign flag is 0;
  - clear the counter and go to RUN.
- Magnitude of 0x80000000 is 0x80000000 (unsigned interpretation).
- RUN, each cycle:
  - if product[0] is set, add the multiplicand to product[2W-1:W] as a (W+1)-bit sum, carry kept;
  - shift the {carry, product} concatenation right by 1;
  - increment the counter.
- After 32 iterations (counter reaches 31 and its step completes), go to FIN.
- FIN, one cycle:
  - HI/LO ← product, two's-complement negated across all 64 bits if the sign flag is set;
  - assert `done` and return to IDLE.
- Requests while not IDLE: a multiply funct with `ex_valid` is not accepted. Upstream holds the instruction because `stall` is high.
- `stall` = `ex_valid` & (`multCtl` ∈ {F_MULT, F_MULTU, F_MFHI, F_MFLO}) & (state ≠ IDLE).
- `mf_data` in IDLE reflects the current HI/LO. In the FIN cycle it still shows the old values, and `stall` is asserted.
- Other funct codes (including sll 6'd0) have no effect.
- A low `rst_n` in RUN or FIN aborts the operation: no `done`, HI/LO cleared.

## Timing
- Call the accept edge cycle 0. RUN occupies cycles 1–32, FIN is cycle 33, and HI/LO update on the cycle 33→34 edge.
- Back-to-back: the next multiply is acceptable in cycle 34, giving a 34-cycle issue interval.
- This is consistent with ALU control's 33-count HiLo-enable window.
- `busy` is high in cycles 1–33. `done` is high only in cycle 33.
- An `mfhi` presented in cycle 34 returns the new HI with zero extra latency.

## Structure
- Funct constants (F_MULT, F_MULTU, F_MFHI, F_MFLO) and the state encoding belong in a shared package, `mips_pkg`, also used by ALU control.
- One natural sub-module: `shift_add_step`, a combinational single iteration (add-if-LSB, then shift) over the {carry, product} vector.
- The FSM, counter, sign handling and HI/LO stay in this block.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `hi`=`lo`=0, `busy`=0, `done`=0, `stall`=0.
- `multu` 0xFFFFFFFF × 0xFFFFFFFF → `done` in cycle 33; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- `mult` −3 (0xFFFFFFFD) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `mult` 0x80000000 × 2 → `hi`=0xFFFFFFFF, `lo`=0x00000000.
- `mflo` presented in cycle 5 of a multiply → `stall`=1 through cycle 33; in cycle 34 `mf_data` = new LO and `stall`=0.
- Second `mult` issued in cycle 10 → ignored with `stall`=1; accepted in cycle 34; its `done` arrives in cycle 67.
- `rst_n`=0 in cycle 20 of a run → state IDLE, no `done`, `hi`=`lo`=0; a new multiply is accepted in the next cycle.
